// File: rtl/gate_truth_checker.sv
// Exhaustive truth-table checker: walks a gate through every input vector and
// compares its output to a reference. Optional macro: STOP_ON_ERR_EN.
module gate_truth_checker #(
  parameter int N_INPUTS    = 2,
  parameter int HOLD_CYCLES = 2,
  parameter int ERR_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [2:0]          mode,
  output logic [N_INPUTS-1:0] stim,
  input  logic                dut_q,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ERR_W-1:0]    err_count,
  output logic                first_err_valid,
  output logic [N_INPUTS-1:0] first_err_vec
);

  // state  | meaning
  // S_IDLE | waiting for the first start after reset
  // S_RUN  | stepping vectors, sampling dut_q in the last hold cycle
  // S_DONE | result valid, waiting for another start

`ifdef STOP_ON_ERR_EN
  localparam bit STOP_ON_ERR = 1'b1;
`else
  localparam bit STOP_ON_ERR = 1'b0;
`endif

  localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       mode_q;
  logic [HC_W-1:0]  hold_cnt;
  logic             accept;
  logic             sample;
  logic             ref_bit;
  logic             mismatch;
  logic             finish;
  logic [ERR_W-1:0] err_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_RUN;
      S_RUN:   if (finish) state_nxt = S_DONE;
      S_DONE:  if (accept) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == S_RUN);
    done     = (state == S_DONE);
    accept   = start && (state != S_RUN);
    sample   = (state == S_RUN) && (hold_cnt == HC_LAST);
    case (mode_q)
      3'd0:    ref_bit = &stim;
      3'd1:    ref_bit = |stim;
      3'd2:    ref_bit = ~&stim;
      3'd3:    ref_bit = ~|stim;
      3'd4:    ref_bit = ^stim;
      3'd5:    ref_bit = ~^stim;
      3'd6:    ref_bit = stim[0];
      default: ref_bit = ~stim[0];
    endcase
    mismatch = sample && (dut_q != ref_bit);
    finish   = sample && ((&stim) || (STOP_ON_ERR && mismatch));
    err_nxt  = (mismatch && !(&err_count)) ? err_count + ERR_W'(1) : err_count;
  end

  // pass is judged on err_nxt so a miss on the final vector still counts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stim            <= '0;
      hold_cnt        <= '0;
      mode_q          <= '0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
    end else if (accept) begin
      stim            <= '0;
      hold_cnt        <= '0;
      mode_q          <= mode;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
    end else if (state == S_RUN) begin
      if (sample) begin
        err_count <= err_nxt;
        if (mismatch && !first_err_valid) begin
          first_err_valid <= 1'b1;
          first_err_vec   <= stim;
        end
        if (finish) begin
          pass <= (err_nxt == '0);
        end else begin
          stim     <= stim + N_INPUTS'(1);
          hold_cnt <= '0;
        end
      end else begin
        hold_cnt <= hold_cnt + HC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Directed bench for gate_truth_checker: 2-input checker with a selectable
// stand-in gate, plus a 3-input / 2-bit-counter instance for saturation.
module tb_gate_truth_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start_a = 1'b0;
  logic [2:0] mode_a  = 3'd0;
  int         gate_a  = 0;
  logic [1:0] stim_a;
  logic       dut_q_a;
  logic       busy_a, done_a, pass_a, fev_a;
  logic [7:0] err_a;
  logic [1:0] fevec_a;

  logic       start_b = 1'b0;
  logic [2:0] mode_b  = 3'd0;
  logic [2:0] stim_b;
  logic       dut_q_b;
  logic       busy_b, done_b, pass_b, fev_b;
  logic [1:0] err_b;
  logic [2:0] fevec_b;

  int checks   = 0;
  int failures = 0;
  int busy_cnt;
  logic [1:0] seq [0:99];

  always #5 clk = ~clk;

  // stand-in gate: 0 NOR, 1 tied 0, 2 AND, 3 tied 1
  always_comb begin
    case (gate_a)
      0:       dut_q_a = ~|stim_a;
      1:       dut_q_a = 1'b0;
      2:       dut_q_a = &stim_a;
      3:       dut_q_a = 1'b1;
      default: dut_q_a = 1'b0;
    endcase
  end
  assign dut_q_b = ~&stim_b;

  gate_truth_checker #(.N_INPUTS(2), .HOLD_CYCLES(2), .ERR_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .mode(mode_a), .stim(stim_a),
    .dut_q(dut_q_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .first_err_valid(fev_a), .first_err_vec(fevec_a));

  gate_truth_checker #(.N_INPUTS(3), .HOLD_CYCLES(2), .ERR_W(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .mode(mode_b), .stim(stim_b),
    .dut_q(dut_q_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .first_err_valid(fev_b), .first_err_vec(fevec_b));

  task automatic run_a(input logic [2:0] m, input int g, input bit flip_mode);
    @(negedge clk);
    mode_a  = m;
    gate_a  = g;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    if (flip_mode) mode_a = ~m;
    checks++;
    if (busy_a !== 1'b1 || done_a !== 1'b0 || err_a !== 8'd0 || fev_a !== 1'b0) begin
      failures++;
      $display("FAIL run_start busy=%b done=%b err=%0d fev=%b expected busy=1 done=0 err=0 fev=0",
               busy_a, done_a, err_a, fev_a);
    end
    busy_cnt = 0;
    while (busy_a === 1'b1 && busy_cnt < 100) begin
      seq[busy_cnt] = stim_a;
      busy_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if ({stim_a, busy_a, done_a, pass_a, err_a, fev_a, fevec_a} !== '0) begin
      failures++;
      $display("FAIL reset_a stim=%0d busy=%b done=%b pass=%b err=%0d fev=%b fevec=%0d expected all 0",
               stim_a, busy_a, done_a, pass_a, err_a, fev_a, fevec_a);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({stim_b, busy_b, done_b, pass_b, err_b, fev_b, fevec_b} !== '0) begin
      failures++;
      $display("FAIL reset_b stim=%0d busy=%b done=%b err=%0d expected all 0",
               stim_b, busy_b, done_b, err_b);
    end
  endtask

  task automatic test_nor_pass;
    run_a(3'd3, 0, 1'b1);
    checks++;
    if (busy_cnt !== 8) begin
      failures++;
      $display("FAIL nor_busy_len got=%0d expected=8", busy_cnt);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (seq[i] !== 2'(i / 2)) begin
        failures++;
        $display("FAIL nor_stim_seq[%0d] got=%0d expected=%0d", i, seq[i], i / 2);
      end
    end
    checks++;
    if (done_a !== 1'b1 || pass_a !== 1'b1 || err_a !== 8'd0 || fev_a !== 1'b0 || stim_a !== 2'd3) begin
      failures++;
      $display("FAIL nor_result done=%b pass=%b err=%0d fev=%b stim=%0d expected 1 1 0 0 3",
               done_a, pass_a, err_a, fev_a, stim_a);
    end
  endtask

  task automatic test_tied_low;
    run_a(3'd3, 1, 1'b0);
    checks++;
    if (busy_cnt !== 8 || err_a !== 8'd1 || fev_a !== 1'b1 || fevec_a !== 2'd0 ||
        pass_a !== 1'b0 || done_a !== 1'b1) begin
      failures++;
      $display("FAIL tied_low len=%0d err=%0d fev=%b fevec=%0d pass=%b done=%b expected 8 1 1 0 0 1",
               busy_cnt, err_a, fev_a, fevec_a, pass_a, done_a);
    end
  endtask

  task automatic test_xor_vs_and;
    run_a(3'd4, 2, 1'b0);
    checks++;
    if (busy_cnt !== 8 || err_a !== 8'd3 || fevec_a !== 2'd1 || pass_a !== 1'b0 || fev_a !== 1'b1) begin
      failures++;
      $display("FAIL xor_vs_and len=%0d err=%0d fevec=%0d pass=%b fev=%b expected 8 3 1 0 1",
               busy_cnt, err_a, fevec_a, pass_a, fev_a);
    end
  endtask

  task automatic test_saturate;
    int n;
    @(negedge clk);
    mode_b  = 3'd0;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    n = 0;
    while (busy_b === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== 16 || err_b !== 2'd3 || fev_b !== 1'b1 || fevec_b !== 3'd0 ||
        pass_b !== 1'b0 || done_b !== 1'b1) begin
      failures++;
      $display("FAIL saturate len=%0d err=%0d fev=%b fevec=%0d pass=%b done=%b expected 16 3 1 0 0 1",
               n, err_b, fev_b, fevec_b, pass_b, done_b);
    end
  endtask

  task automatic test_restart_and_abort;
    @(negedge clk);
    mode_a  = 3'd3;
    gate_a  = 0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start_a = 1'b1;
    mode_a  = 3'd0;
    @(negedge clk);
    start_a = 1'b0;
    checks++;
    if (stim_a !== 2'd1 || busy_a !== 1'b1) begin
      failures++;
      $display("FAIL ignore_start stim=%0d busy=%b expected stim=1 busy=1", stim_a, busy_a);
    end
    @(negedge clk);
    checks++;
    if (stim_a !== 2'd2) begin
      failures++;
      $display("FAIL mid_run_stim got=%0d expected=2", stim_a);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({stim_a, busy_a, done_a, pass_a, err_a, fev_a, fevec_a} !== '0) begin
      failures++;
      $display("FAIL async_abort stim=%0d busy=%b done=%b pass=%b err=%0d fev=%b expected all 0",
               stim_a, busy_a, done_a, pass_a, err_a, fev_a);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || stim_a !== 2'd0) begin
      failures++;
      $display("FAIL idle_after_abort busy=%b done=%b stim=%0d expected 0 0 0", busy_a, done_a, stim_a);
    end
    run_a(3'd3, 0, 1'b0);
    checks++;
    if (busy_cnt !== 8 || pass_a !== 1'b1 || done_a !== 1'b1 || err_a !== 8'd0) begin
      failures++;
      $display("FAIL rerun len=%0d pass=%b done=%b err=%0d expected 8 1 1 0", busy_cnt, pass_a, done_a, err_a);
    end
  endtask

  task automatic test_stop_on_err;
    run_a(3'd1, 3, 1'b0);
`ifdef STOP_ON_ERR_EN
    checks++;
    if (busy_cnt !== 2 || err_a !== 8'd1 || done_a !== 1'b1 || stim_a !== 2'd0 ||
        pass_a !== 1'b0 || fevec_a !== 2'd0) begin
      failures++;
      $display("FAIL stop_on_err len=%0d err=%0d done=%b stim=%0d pass=%b fevec=%0d expected 2 1 1 0 0 0",
               busy_cnt, err_a, done_a, stim_a, pass_a, fevec_a);
    end
`else
    checks++;
    if (busy_cnt !== 8 || err_a !== 8'd1 || done_a !== 1'b1 || stim_a !== 2'd3 ||
        pass_a !== 1'b0 || fevec_a !== 2'd0) begin
      failures++;
      $display("FAIL full_run_or len=%0d err=%0d done=%b stim=%0d pass=%b fevec=%0d expected 8 1 1 3 0 0",
               busy_cnt, err_a, done_a, stim_a, pass_a, fevec_a);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_nor_pass();
    test_tied_low();
    test_xor_vs_and();
    test_saturate();
    test_restart_and_abort();
    test_stop_on_err();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gate_truth_checker.md
Name: gate_truth_checker

Overview:
Parametrised, self-running exhaustive truth-table checker for N-input basic gates.
- Steps a DUT gate through all 2^N_INPUTS input combinations and holds each vector for a programmable settle time.
- Samples the DUT output, compares it against a built-in reference function chosen by mode, and reports the error count, the first failing vector and a pass flag.
- Replaces per-gate hand-written stimulus sequences; sits beside any gate instance in on-chip or simulation self-test.

Parameters:
N_INPUTS, 2, gate input count (1..8); stim width, 2^N_INPUTS vectors per run.
HOLD_CYCLES, 2, cycles each vector is held (>=1); dut_q is sampled in the last hold cycle.
ERR_W, 8, error counter width; the counter saturates at 2^ERR_W-1.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
start  input  1  one-cycle request to begin a run; honoured only in IDLE or DONE
mode  input  3  reference function, latched on accepted start: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 BUF(stim[0]), 7 NOT(stim[0])
stim  output  N_INPUTS  registered vector driven to the DUT inputs
dut_q  input  1  DUT gate output
busy  output  1  high while a run is in progress
done  output  1  high from run end until the next accepted start
pass  output  1  valid when done=1; high iff err_count==0
err_count  output  ERR_W  saturating count of mismatching vectors
first_err_valid  output  1  at least one mismatch seen in the current run
first_err_vec  output  N_INPUTS  stim value of the first mismatch

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values (on rst assertion, immediate): state=IDLE; stim, busy, done, pass, err_count, first_err_valid and first_err_vec all 0; hold counter 0.
- States: IDLE, RUN, DONE.
  - IDLE/DONE --start=1--> RUN. Next edge: stim=0, busy=1, done=0, pass=0, err_count=0, first_err_valid=0, first_err_vec=0, mode latched.
  - RUN: the hold counter counts 0..HOLD_CYCLES-1 per vector.
    - On the cycle with hold counter = HOLD_CYCLES-1, compare dut_q to ref(mode_latched, stim).
    - Mismatch: err_count+1, saturating at all-ones.
    - If first_err_valid=0 on a mismatch: first_err_vec<=stim, first_err_valid<=1.
    - Then, if stim is not all-ones: stim+1 and hold counter=0.
    - If stim is all-ones: go to DONE.
  - RUN->DONE edge: busy=0, done=1, pass=(final err_count==0), including a mismatch on the last vector. stim keeps its final value.
- Run length: exactly 2^N_INPUTS*HOLD_CYCLES cycles of busy=1. done rises on the edge after the last sample.
- Reference function: AND/OR/XOR reduce over all stim bits; NAND/NOR/XNOR are their complements. BUF/NOT use stim[0] only. N_INPUTS=1 makes AND=OR=XOR=BUF.
- start while busy=1: ignored; the run continues unchanged.
- mode changes mid-run: no effect, because the latched copy is used.
- rst mid-run: abort immediately to reset values. No partial result is retained.
- dut_q is treated as settled at the sample cycle. No metastability handling.

Optional Feature:
STOP_ON_ERR_EN
- Defined: the first mismatch ends the run. The next edge goes to DONE with done=1, pass=0, err_count=1, first_err_vec set, and stim held at the failing vector. Run length is variable.
- Undefined: all vectors are always exercised, as described above.

Test Plan:
- N_INPUTS=2, HOLD_CYCLES=2, mode=3 (NOR), dut_q=~|stim -> busy high exactly 8 cycles, stim sequence 0,0,1,1,2,2,3,3; done=1, pass=1, err_count=0, first_err_valid=0.
- Same config, dut_q tied 0 -> mismatch only at stim=2'b00; err_count=1, first_err_vec=2'b00, pass=0.
- mode=4 (XOR), DUT is AND -> mismatches at 01, 10, 11; err_count=3, first_err_vec=2'b01, pass=0.
- N_INPUTS=3, ERR_W=2, mode=0, dut_q=~&stim (all 8 wrong) -> err_count saturates at 3, first_err_vec=3'b000, pass=0.
- start pulsed again at cycle 3 of a run, then rst asserted at cycle 5 -> second start ignored; rst asynchronously clears all outputs to 0 before the next edge; state IDLE; a new start runs cleanly to pass=1.
- STOP_ON_ERR_EN defined, mode=1 (OR), dut_q tied 1 -> stops at stim=2'b00 after 2 busy cycles; err_count=1, done=1, stim=2'b00.
